// File: rtl/ysyx_25010008_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the IFU (m0, read-only)
// and the LSU (m1). One whole transaction is granted at a time, with a response watchdog.
module ysyx_25010008_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            m0_req_valid,
  input  logic [AW-1:0]   m0_req_addr,
  output logic            m0_req_ready,
  output logic            m0_rsp_valid,
  output logic [DW-1:0]   m0_rsp_data,
  output logic [1:0]      m0_rsp_resp,
  input  logic            m0_rsp_ready,
  input  logic            m1_req_valid,
  input  logic            m1_req_we,
  input  logic [AW-1:0]   m1_req_addr,
  input  logic [DW-1:0]   m1_req_wdata,
  input  logic [DW/8-1:0] m1_req_wstrb,
  output logic            m1_req_ready,
  output logic            m1_rsp_valid,
  output logic [DW-1:0]   m1_rsp_data,
  output logic [1:0]      m1_rsp_resp,
  input  logic            m1_rsp_ready,
  output logic            s_req_valid,
  output logic            s_req_we,
  output logic [AW-1:0]   s_req_addr,
  output logic [DW-1:0]   s_req_wdata,
  output logic [DW/8-1:0] s_req_wstrb,
  input  logic            s_req_ready,
  input  logic            s_rsp_valid,
  input  logic [DW-1:0]   s_rsp_data,
  input  logic [1:0]      s_rsp_resp,
  output logic            s_rsp_ready
);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RSP, ABORT} state_t;

  state_t        state, state_nxt;
  logic          gnt, gnt_nxt;
  logic          last, last_nxt;
  logic          we_q, we_nxt;
  logic [CW-1:0] wdog, wdog_nxt;

  logic          rsp_v;
  logic [DW-1:0] rsp_d;
  logic [1:0]    rsp_r;
  logic          rsp_ack;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      gnt   <= 1'b0;
      last  <= 1'b1;
      we_q  <= 1'b0;
      wdog  <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      last  <= last_nxt;
      we_q  <= we_nxt;
      wdog  <= wdog_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    last_nxt     = last;
    we_nxt       = we_q;
    wdog_nxt     = wdog;
    m0_req_ready = 1'b0;
    m1_req_ready = 1'b0;
    s_req_valid  = 1'b0;
    s_req_we     = 1'b0;
    s_req_addr   = '0;
    s_req_wdata  = '0;
    s_req_wstrb  = '0;
    s_rsp_ready  = 1'b0;
    rsp_v        = 1'b0;
    rsp_d        = '0;
    rsp_r        = 2'b00;
    rsp_ack      = gnt ? m1_rsp_ready : m0_rsp_ready;
    // Every output stays quiet while reset is held low.
    if (reset) begin
      case (state)
        IDLE: begin
          s_rsp_ready = 1'b1;
          if (m0_req_valid && m1_req_valid) begin
            gnt_nxt   = ~last;
            state_nxt = REQ;
          end else if (m0_req_valid || m1_req_valid) begin
            gnt_nxt   = m1_req_valid;
            state_nxt = REQ;
          end
        end
        REQ: begin
          s_req_valid = 1'b1;
          if (gnt) begin
            s_req_we     = m1_req_we;
            s_req_addr   = m1_req_addr;
            s_req_wdata  = m1_req_wdata;
            s_req_wstrb  = m1_req_wstrb;
            m1_req_ready = s_req_ready;
          end else begin
            s_req_addr   = m0_req_addr;
            m0_req_ready = s_req_ready;
          end
          if (s_req_ready) begin
            state_nxt = RSP;
            wdog_nxt  = '0;
            we_nxt    = gnt & m1_req_we;
          end
        end
        RSP: begin
          s_rsp_ready = rsp_ack;
          rsp_v       = s_rsp_valid;
          rsp_d       = we_q ? '0 : s_rsp_data;
          rsp_r       = s_rsp_resp;
          if (s_rsp_valid && rsp_ack) begin
            last_nxt  = gnt;
            state_nxt = IDLE;
          end else begin
            wdog_nxt = wdog + 1'b1;
            if (TIMEOUT != 0 && wdog_nxt == CW'(TIMEOUT)) state_nxt = ABORT;
          end
        end
        ABORT: begin
          // Synthesized error response; any late slave reply is drained in IDLE.
          rsp_v = 1'b1;
          rsp_r = 2'b11;
          if (rsp_ack) begin
            last_nxt  = gnt;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign m0_rsp_valid = rsp_v & ~gnt;
  assign m0_rsp_data  = gnt ? '0 : rsp_d;
  assign m0_rsp_resp  = gnt ? 2'b00 : rsp_r;
  assign m1_rsp_valid = rsp_v & gnt;
  assign m1_rsp_data  = gnt ? rsp_d : '0;
  assign m1_rsp_resp  = gnt ? rsp_r : 2'b00;
endmodule

// File: tb/tb_ysyx_25010008_mem_arbiter.sv
// Bench for the two-master memory arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference of the arbitration rules.
module tb_ysyx_25010008_mem_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req_valid, m0_rsp_ready, m1_req_valid, m1_req_we, m1_rsp_ready;
  logic [31:0] m0_req_addr, m1_req_addr, m1_req_wdata, s_rsp_data;
  logic [3:0]  m1_req_wstrb;
  logic        s_req_ready, s_rsp_valid;
  logic [1:0]  s_rsp_resp;

  logic        m0_req_ready, m0_rsp_valid, m1_req_ready, m1_rsp_valid;
  logic [31:0] m0_rsp_data, m1_rsp_data, s_req_addr, s_req_wdata;
  logic [1:0]  m0_rsp_resp, m1_rsp_resp;
  logic        s_req_valid, s_req_we, s_rsp_ready;
  logic [3:0]  s_req_wstrb;

  logic        t_m0_req_ready, t_m0_rsp_valid, t_m1_req_ready, t_m1_rsp_valid;
  logic [31:0] t_m0_rsp_data, t_m1_rsp_data, t_s_req_addr, t_s_req_wdata;
  logic [1:0]  t_m0_rsp_resp, t_m1_rsp_resp;
  logic        t_s_req_valid, t_s_req_we, t_s_rsp_ready;
  logic [3:0]  t_s_req_wstrb;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  ysyx_25010008_mem_arbiter dut (
    .clock(clock), .reset(reset),
    .m0_req_valid(m0_req_valid), .m0_req_addr(m0_req_addr), .m0_req_ready(m0_req_ready),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_data(m0_rsp_data), .m0_rsp_resp(m0_rsp_resp),
    .m0_rsp_ready(m0_rsp_ready),
    .m1_req_valid(m1_req_valid), .m1_req_we(m1_req_we), .m1_req_addr(m1_req_addr),
    .m1_req_wdata(m1_req_wdata), .m1_req_wstrb(m1_req_wstrb), .m1_req_ready(m1_req_ready),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_data(m1_rsp_data), .m1_rsp_resp(m1_rsp_resp),
    .m1_rsp_ready(m1_rsp_ready),
    .s_req_valid(s_req_valid), .s_req_we(s_req_we), .s_req_addr(s_req_addr),
    .s_req_wdata(s_req_wdata), .s_req_wstrb(s_req_wstrb), .s_req_ready(s_req_ready),
    .s_rsp_valid(s_rsp_valid), .s_rsp_data(s_rsp_data), .s_rsp_resp(s_rsp_resp),
    .s_rsp_ready(s_rsp_ready)
  );

  ysyx_25010008_mem_arbiter #(.TIMEOUT(4)) dut_t (
    .clock(clock), .reset(reset),
    .m0_req_valid(m0_req_valid), .m0_req_addr(m0_req_addr), .m0_req_ready(t_m0_req_ready),
    .m0_rsp_valid(t_m0_rsp_valid), .m0_rsp_data(t_m0_rsp_data), .m0_rsp_resp(t_m0_rsp_resp),
    .m0_rsp_ready(m0_rsp_ready),
    .m1_req_valid(m1_req_valid), .m1_req_we(m1_req_we), .m1_req_addr(m1_req_addr),
    .m1_req_wdata(m1_req_wdata), .m1_req_wstrb(m1_req_wstrb), .m1_req_ready(t_m1_req_ready),
    .m1_rsp_valid(t_m1_rsp_valid), .m1_rsp_data(t_m1_rsp_data), .m1_rsp_resp(t_m1_rsp_resp),
    .m1_rsp_ready(m1_rsp_ready),
    .s_req_valid(t_s_req_valid), .s_req_we(t_s_req_we), .s_req_addr(t_s_req_addr),
    .s_req_wdata(t_s_req_wdata), .s_req_wstrb(t_s_req_wstrb), .s_req_ready(s_req_ready),
    .s_rsp_valid(s_rsp_valid), .s_rsp_data(s_rsp_data), .s_rsp_resp(s_rsp_resp),
    .s_rsp_ready(t_s_rsp_ready)
  );

  wire [150:0] all_out = {m0_req_ready, m0_rsp_valid, m0_rsp_data, m0_rsp_resp, m1_req_ready,
                          m1_rsp_valid, m1_rsp_data, m1_rsp_resp, s_req_valid, s_req_we,
                          s_req_addr, s_req_wdata, s_req_wstrb, s_rsp_ready};
  wire [150:0] t_all_out = {t_m0_req_ready, t_m0_rsp_valid, t_m0_rsp_data, t_m0_rsp_resp,
                            t_m1_req_ready, t_m1_rsp_valid, t_m1_rsp_data, t_m1_rsp_resp,
                            t_s_req_valid, t_s_req_we, t_s_req_addr, t_s_req_wdata,
                            t_s_req_wstrb, t_s_rsp_ready};

  task automatic clear_inputs;
    m0_req_valid = 0; m0_req_addr = 0; m0_rsp_ready = 0;
    m1_req_valid = 0; m1_req_we = 0; m1_req_addr = 0; m1_req_wdata = 0; m1_req_wstrb = 0;
    m1_rsp_ready = 0; s_req_ready = 0; s_rsp_valid = 0; s_rsp_data = 0; s_rsp_resp = 0;
  endtask

  task automatic do_reset;
    @(negedge clock);
    reset = 0;
    clear_inputs();
    repeat (2) @(negedge clock);
    reset = 1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      reset = 0;
      m0_req_valid = 1; m1_req_valid = 1; m1_req_we = 1;
      m0_req_addr = $urandom; m1_req_addr = $urandom; m1_req_wdata = $urandom;
      m1_req_wstrb = 4'hF; s_req_ready = 1; s_rsp_valid = 1; s_rsp_data = $urandom;
      s_rsp_resp = 2'b01; m0_rsp_ready = 1; m1_rsp_ready = 1;
      #1;
      total++;
      if (all_out !== '0) begin
        bad++; $display("FAIL reset_outputs cycle %0d: got %h want 0", i, all_out);
      end
      total++;
      if (t_all_out !== '0) begin
        bad++; $display("FAIL reset_outputs_t cycle %0d: got %h want 0", i, t_all_out);
      end
    end
    clear_inputs();
    @(negedge clock);
    reset = 1;
    #1;
    total++;
    if (s_rsp_ready !== 1'b1 || s_req_valid !== 1'b0) begin
      bad++; $display("FAIL reset_idle: s_rsp_ready=%b s_req_valid=%b want 1/0", s_rsp_ready, s_req_valid);
    end
  endtask

  task automatic test_ifu_read;
    do_reset();
    @(negedge clock); m0_req_valid = 1; m0_req_addr = 32'h3000_0000; #1;
    total++;
    if (m0_req_ready !== 0 || s_req_valid !== 0) begin
      bad++; $display("FAIL ifu_c0: req_ready=%b s_req_valid=%b want 0/0", m0_req_ready, s_req_valid);
    end
    @(negedge clock); #1;
    total++;
    if (s_req_valid !== 1 || s_req_addr !== 32'h3000_0000 || m0_req_ready !== 0) begin
      bad++; $display("FAIL ifu_c1: v=%b addr=%h rdy=%b want 1/30000000/0", s_req_valid, s_req_addr, m0_req_ready);
    end
    @(negedge clock); s_req_ready = 1; #1;
    total++;
    if (m0_req_ready !== 1) begin
      bad++; $display("FAIL ifu_c2_ready: got %b want 1", m0_req_ready);
    end
    @(negedge clock); m0_req_valid = 0; s_req_ready = 0; m0_rsp_ready = 1; #1;
    total++;
    if (s_req_valid !== 0 || m0_rsp_valid !== 0 || s_rsp_ready !== 1) begin
      bad++; $display("FAIL ifu_c3: sv=%b rv=%b srr=%b want 0/0/1", s_req_valid, m0_rsp_valid, s_rsp_ready);
    end
    @(negedge clock); s_rsp_valid = 1; s_rsp_data = 32'h0000_0413; s_rsp_resp = 0; #1;
    total++;
    if (m0_rsp_valid !== 1 || m0_rsp_data !== 32'h413 || m0_rsp_resp !== 0 || m1_rsp_valid !== 0) begin
      bad++; $display("FAIL ifu_c4_rsp: v=%b d=%h r=%b m1v=%b want 1/413/0/0",
                      m0_rsp_valid, m0_rsp_data, m0_rsp_resp, m1_rsp_valid);
    end
    @(negedge clock); s_rsp_valid = 0; m0_rsp_ready = 0; #1;
    total++;
    if (s_rsp_ready !== 1 || s_req_valid !== 0 || m0_rsp_valid !== 0) begin
      bad++; $display("FAIL ifu_c5_idle: srr=%b sv=%b rv=%b want 1/0/0", s_rsp_ready, s_req_valid, m0_rsp_valid);
    end
  endtask

  task automatic test_simultaneous;
    do_reset();
    @(negedge clock);
    m0_req_valid = 1; m0_req_addr = 32'h3000_0004;
    m1_req_valid = 1; m1_req_we = 1; m1_req_addr = 32'h8000_0000;
    m1_req_wdata = 32'hDEAD_BEEF; m1_req_wstrb = 4'hF;
    m0_rsp_ready = 1; m1_rsp_ready = 1;
    @(negedge clock); s_req_ready = 1; #1;
    total++;
    if (s_req_addr !== 32'h3000_0004 || s_req_we !== 0 || s_req_wdata !== 0 || s_req_wstrb !== 0 ||
        m0_req_ready !== 1 || m1_req_ready !== 0) begin
      bad++; $display("FAIL sim_first_m0: addr=%h we=%b wd=%h st=%h r0=%b r1=%b want 30000004/0/0/0/1/0",
                      s_req_addr, s_req_we, s_req_wdata, s_req_wstrb, m0_req_ready, m1_req_ready);
    end
    @(negedge clock); m0_req_valid = 0; s_req_ready = 0;
    s_rsp_valid = 1; s_rsp_data = 32'h1111_2222; s_rsp_resp = 2'b00; #1;
    total++;
    if (m0_rsp_valid !== 1 || m0_rsp_data !== 32'h1111_2222 || m1_rsp_valid !== 0) begin
      bad++; $display("FAIL sim_m0_rsp: v=%b d=%h m1v=%b want 1/11112222/0", m0_rsp_valid, m0_rsp_data, m1_rsp_valid);
    end
    @(negedge clock); s_rsp_valid = 0; #1;
    @(negedge clock); s_req_ready = 1; #1;
    total++;
    if (s_req_valid !== 1 || s_req_we !== 1 || s_req_addr !== 32'h8000_0000 ||
        s_req_wdata !== 32'hDEAD_BEEF || s_req_wstrb !== 4'hF || m1_req_ready !== 1) begin
      bad++; $display("FAIL sim_m1_write: v=%b we=%b addr=%h wd=%h st=%h r1=%b want 1/1/80000000/deadbeef/f/1",
                      s_req_valid, s_req_we, s_req_addr, s_req_wdata, s_req_wstrb, m1_req_ready);
    end
    @(negedge clock); m1_req_valid = 0; s_req_ready = 0;
    s_rsp_valid = 1; s_rsp_data = 32'h1234_5678; s_rsp_resp = 2'b01; #1;
    total++;
    if (m1_rsp_valid !== 1 || m1_rsp_data !== 0 || m1_rsp_resp !== 2'b01) begin
      bad++; $display("FAIL sim_m1_wrsp: v=%b d=%h r=%b want 1/0/01", m1_rsp_valid, m1_rsp_data, m1_rsp_resp);
    end
    @(negedge clock); s_rsp_valid = 0; m0_req_valid = 1; m1_req_valid = 1; #1;
    @(negedge clock); #1;
    total++;
    if (s_req_valid !== 1 || s_req_we !== 0 || s_req_addr !== 32'h3000_0004) begin
      bad++; $display("FAIL sim_next_m0: v=%b we=%b addr=%h want 1/0/30000004", s_req_valid, s_req_we, s_req_addr);
    end
  endtask

  task automatic test_fairness;
    int n;
    logic g[6];
    n = 0;
    do_reset();
    @(negedge clock);
    m0_req_valid = 1; m0_req_addr = 32'h3000_0010;
    m1_req_valid = 1; m1_req_we = 0; m1_req_addr = 32'h8000_0020;
    s_req_ready = 1; s_rsp_valid = 1; s_rsp_data = 32'h55; m0_rsp_ready = 1; m1_rsp_ready = 1;
    for (int c = 0; c < 40 && n < 6; c++) begin
      @(negedge clock); #1;
      if (m0_req_ready === 1) begin g[n] = 0; n++; end
      else if (m1_req_ready === 1) begin g[n] = 1; n++; end
    end
    total++;
    if (n != 6) begin
      bad++; $display("FAIL fair_budget: grants=%0d want 6", n);
    end
    for (int i = 0; i < n; i++) begin
      total++;
      if (g[i] !== i[0]) begin
        bad++; $display("FAIL fair_grant[%0d]: got m%0d want m%0d", i, g[i], i % 2);
      end
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    @(negedge clock); m1_req_valid = 1; m1_req_we = 0; m1_req_addr = 32'h8000_0010;
    @(negedge clock); s_req_ready = 1; #1;
    total++;
    if (m1_req_ready !== 1) begin
      bad++; $display("FAIL bp_accept: got %b want 1", m1_req_ready);
    end
    @(negedge clock);
    m1_req_valid = 0; s_req_ready = 0; s_rsp_valid = 1; s_rsp_data = 32'hCAFE_0001; s_rsp_resp = 0;
    m1_rsp_ready = 0; m0_req_valid = 1; m0_req_addr = 32'h3000_0100;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clock);
      #1;
      total++;
      if (s_rsp_ready !== 0 || m1_rsp_valid !== 1 || m1_rsp_data !== 32'hCAFE_0001 ||
          m0_req_ready !== 0 || s_req_valid !== 0) begin
        bad++; $display("FAIL bp_hold[%0d]: srr=%b v=%b d=%h r0=%b sv=%b want 0/1/cafe0001/0/0",
                        i, s_rsp_ready, m1_rsp_valid, m1_rsp_data, m0_req_ready, s_req_valid);
      end
    end
    @(negedge clock); m1_rsp_ready = 1; #1;
    total++;
    if (s_rsp_ready !== 1) begin
      bad++; $display("FAIL bp_release: got %b want 1", s_rsp_ready);
    end
    @(negedge clock); s_rsp_valid = 0; m1_rsp_ready = 0; #1;
    total++;
    if (s_req_valid !== 0) begin
      bad++; $display("FAIL bp_idle_gap: s_req_valid=%b want 0", s_req_valid);
    end
    @(negedge clock); #1;
    total++;
    if (s_req_valid !== 1 || s_req_addr !== 32'h3000_0100 || s_req_we !== 0) begin
      bad++; $display("FAIL bp_m0_after: v=%b addr=%h we=%b want 1/30000100/0", s_req_valid, s_req_addr, s_req_we);
    end
  endtask

  task automatic test_timeout;
    do_reset();
    @(negedge clock); m0_req_valid = 1; m0_req_addr = 32'h3000_0200;
    @(negedge clock); s_req_ready = 1;
    @(negedge clock); m0_req_valid = 0; s_req_ready = 0; m0_rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clock);
      #1;
      total++;
      if (t_m0_rsp_valid !== 0) begin
        bad++; $display("FAIL to_early[%0d]: rsp_valid=%b want 0", i, t_m0_rsp_valid);
      end
    end
    @(negedge clock); m0_rsp_ready = 0; #1;
    total++;
    if (t_m0_rsp_valid !== 1 || t_m0_rsp_resp !== 2'b11 || t_m0_rsp_data !== 0 || t_m1_rsp_valid !== 0) begin
      bad++; $display("FAIL to_abort: v=%b r=%b d=%h m1v=%b want 1/11/0/0",
                      t_m0_rsp_valid, t_m0_rsp_resp, t_m0_rsp_data, t_m1_rsp_valid);
    end
    @(negedge clock); m0_rsp_ready = 1; #1;
    total++;
    if (t_m0_rsp_valid !== 1 || t_m0_rsp_resp !== 2'b11) begin
      bad++; $display("FAIL to_abort_hold: v=%b r=%b want 1/11", t_m0_rsp_valid, t_m0_rsp_resp);
    end
    @(negedge clock); m0_rsp_ready = 0; s_rsp_valid = 1; s_rsp_data = 32'h7777_7777; #1;
    total++;
    if (t_s_rsp_ready !== 1 || t_m0_rsp_valid !== 0 || t_m1_rsp_valid !== 0) begin
      bad++; $display("FAIL to_stale_drain: srr=%b m0v=%b m1v=%b want 1/0/0",
                      t_s_rsp_ready, t_m0_rsp_valid, t_m1_rsp_valid);
    end
    @(negedge clock); s_rsp_valid = 0; #1;
    total++;
    if (t_m0_rsp_valid !== 0 || t_s_req_valid !== 0) begin
      bad++; $display("FAIL to_after_idle: m0v=%b sv=%b want 0/0", t_m0_rsp_valid, t_s_req_valid);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    @(negedge clock); m1_req_valid = 1; m1_req_we = 1; m1_req_addr = 32'h8000_0040;
    m1_req_wdata = 32'hA5A5_A5A5; m1_req_wstrb = 4'h3; m0_req_addr = 32'h3000_0300;
    @(negedge clock); #1;
    total++;
    if (s_req_valid !== 1 || s_req_we !== 1 || s_req_addr !== 32'h8000_0040) begin
      bad++; $display("FAIL rm_m1_req: v=%b we=%b addr=%h want 1/1/80000040", s_req_valid, s_req_we, s_req_addr);
    end
    @(negedge clock); reset = 0; m0_req_valid = 1; #1;
    total++;
    if (all_out !== '0) begin
      bad++; $display("FAIL rm_during_reset: got %h want 0", all_out);
    end
    @(negedge clock); reset = 1; #1;
    total++;
    if (s_req_valid !== 0 || m0_req_ready !== 0 || m1_req_ready !== 0 || s_rsp_ready !== 1) begin
      bad++; $display("FAIL rm_idle: sv=%b r0=%b r1=%b srr=%b want 0/0/0/1",
                      s_req_valid, m0_req_ready, m1_req_ready, s_rsp_ready);
    end
    @(negedge clock); #1;
    total++;
    if (s_req_valid !== 1 || s_req_we !== 0 || s_req_addr !== 32'h3000_0300) begin
      bad++; $display("FAIL rm_m0_wins: v=%b we=%b addr=%h want 1/0/30000300", s_req_valid, s_req_we, s_req_addr);
    end
  endtask

  // Transaction-level reference: phases, round-robin choice, payload routing.
  task automatic test_random;
    localparam int N = 40;
    int ph, left0, left1, done0, done1, dly;
    bit g, lst, acc0, acc1, pend, taken, rwe;
    logic [31:0] rdata, ea, ewd;
    logic [1:0] rresp;
    logic [3:0] es;
    logic ewe, er;
    int cyc;
    ph = 0; left0 = N; left1 = N; done0 = 0; done1 = 0; dly = 0;
    g = 0; lst = 1; acc0 = 0; acc1 = 0; pend = 0; taken = 0; rwe = 0;
    rdata = 0; rresp = 0;
    do_reset();
    for (cyc = 0; cyc < 3000 && (done0 < N || done1 < N); cyc++) begin
      @(negedge clock);
      if (acc0) m0_req_valid = 0;
      if (acc1) m1_req_valid = 0;
      if (taken) pend = 0;
      acc0 = 0; acc1 = 0; taken = 0;
      if (!m0_req_valid && left0 > 0 && $urandom_range(1) == 1) begin
        m0_req_valid = 1; m0_req_addr = $urandom; left0--;
      end
      if (!m1_req_valid && left1 > 0 && $urandom_range(1) == 1) begin
        m1_req_valid = 1; m1_req_we = $urandom_range(1); m1_req_addr = $urandom;
        m1_req_wdata = $urandom; m1_req_wstrb = 4'($urandom); left1--;
      end
      m0_rsp_ready = $urandom_range(1);
      m1_rsp_ready = $urandom_range(1);
      s_req_ready = $urandom_range(1);
      if (pend && dly > 0) dly--;
      s_rsp_valid = pend && dly == 0;
      s_rsp_data = s_rsp_valid ? rdata : $urandom;
      s_rsp_resp = s_rsp_valid ? rresp : 2'($urandom);
      #1;
      total++;
      case (ph)
        0: begin
          if (s_req_valid !== 0 || m0_req_ready !== 0 || m1_req_ready !== 0 || s_rsp_ready !== 1 ||
              m0_rsp_valid !== 0 || m1_rsp_valid !== 0) begin
            bad++; $display("FAIL rnd_idle cyc %0d: sv=%b r0=%b r1=%b srr=%b v0=%b v1=%b want 0/0/0/1/0/0",
                            cyc, s_req_valid, m0_req_ready, m1_req_ready, s_rsp_ready, m0_rsp_valid, m1_rsp_valid);
          end
          if (m0_req_valid || m1_req_valid) begin
            g = (m0_req_valid && m1_req_valid) ? !lst : m1_req_valid;
            ph = 1;
          end
        end
        1: begin
          ea  = g ? m1_req_addr : m0_req_addr;
          ewe = g ? m1_req_we : 1'b0;
          ewd = g ? m1_req_wdata : 32'h0;
          es  = g ? m1_req_wstrb : 4'h0;
          if (s_req_valid !== 1 || s_req_addr !== ea || s_req_we !== ewe || s_req_wdata !== ewd ||
              s_req_wstrb !== es || m0_req_ready !== (!g && s_req_ready) ||
              m1_req_ready !== (g && s_req_ready) || s_rsp_ready !== 0) begin
            bad++; $display("FAIL rnd_req cyc %0d m%0d: addr=%h/%h we=%b/%b wd=%h/%h st=%h/%h r0=%b r1=%b srr=%b",
                            cyc, g, s_req_addr, ea, s_req_we, ewe, s_req_wdata, ewd, s_req_wstrb, es,
                            m0_req_ready, m1_req_ready, s_rsp_ready);
          end
          if (s_req_ready) begin
            ph = 2; rwe = ewe; pend = 1; dly = $urandom_range(3);
            rdata = $urandom; rresp = 2'($urandom);
            if (g) acc1 = 1; else acc0 = 1;
          end
        end
        default: begin
          er = g ? m1_rsp_ready : m0_rsp_ready;
          if (s_req_valid !== 0 || s_rsp_ready !== er ||
              (g ? m1_rsp_valid : m0_rsp_valid) !== s_rsp_valid ||
              (g ? m0_rsp_valid : m1_rsp_valid) !== 0 ||
              (s_rsp_valid && ((g ? m1_rsp_data : m0_rsp_data) !== (rwe ? 32'h0 : rdata) ||
                               (g ? m1_rsp_resp : m0_rsp_resp) !== rresp))) begin
            bad++; $display("FAIL rnd_rsp cyc %0d m%0d: sv=%b srr=%b/%b v0=%b v1=%b d0=%h d1=%h r0=%b r1=%b want d=%h r=%b",
                            cyc, g, s_req_valid, s_rsp_ready, er, m0_rsp_valid, m1_rsp_valid,
                            m0_rsp_data, m1_rsp_data, m0_rsp_resp, m1_rsp_resp,
                            rwe ? 32'h0 : rdata, rresp);
          end
          if (s_rsp_valid && er) begin
            lst = g; ph = 0; taken = 1;
            if (g) done1++; else done0++;
          end
        end
      endcase
    end
    total++;
    if (done0 != N || done1 != N) begin
      bad++; $display("FAIL rnd_complete: done0=%0d done1=%0d want %0d/%0d", done0, done1, N, N);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_ifu_read();
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ysyx_25010008_mem_arbiter.md
Name:
ysyx_25010008_mem_arbiter

Overview:
- Two-master, one-slave arbiter sharing the single memory port between the instruction fetch unit (master 0, read-only) and the load/store unit (master 1, read/write).
- Grants one whole transaction at a time, request through response, with round-robin priority.
- Includes a response watchdog that aborts a hung transaction with an error response.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 255, max cycles in RSP before abort; 0 disables the watchdog.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset (asserted when 0)
m0_req_valid  in  1  IFU request valid
m0_req_addr  in  AW  IFU fetch address
m0_req_ready  out  1  IFU request accepted
m0_rsp_valid  out  1  IFU response valid
m0_rsp_data  out  DW  IFU read data
m0_rsp_resp  out  2  IFU response code
m0_rsp_ready  in  1  IFU accepts response
m1_req_valid  in  1  LSU request valid
m1_req_we  in  1  LSU write enable (1 = write)
m1_req_addr  in  AW  LSU address
m1_req_wdata  in  DW  LSU write data
m1_req_wstrb  in  DW/8  LSU byte strobes
m1_req_ready  out  1  LSU request accepted
m1_rsp_valid  out  1  LSU response valid
m1_rsp_data  out  DW  LSU read data (0 for writes)
m1_rsp_resp  out  2  LSU response code
m1_rsp_ready  in  1  LSU accepts response
s_req_valid/s_req_we/s_req_addr/s_req_wdata/s_req_wstrb  out  1/1/AW/DW/DW/8  request to memory slave
s_req_ready  in  1  slave accepts request
s_rsp_valid/s_rsp_data/s_rsp_resp  in  1/DW/2  slave response
s_rsp_ready  out  1  arbiter accepts slave response

Behaviour:
- Reset (reset == 0 at a clock edge): state = IDLE, gnt = 0, last = 1 (IFU wins first contest), watchdog counter = 0.
- During reset, all valid and ready outputs are 0 and all data outputs are 0.
- Reset asserted mid-transaction returns to IDLE immediately and drops the outstanding transaction. The slave is reset on the same signal.
- All outputs are combinational from registered state and the granted master's inputs.
- Handshake rule on every channel: transfer occurs when valid && ready. A master holds valid and its payload stable until ready.
- IDLE:
  - s_req_valid = 0; both m*_req_ready = 0; s_rsp_ready = 1 (stale or late responses are drained and discarded).
  - One requester valid: gnt = that master, go to REQ.
  - Both valid: gnt = !last, go to REQ.
  - Arbitration costs exactly one cycle. Grant is never given in the same cycle the request appears.
- REQ:
  - s_req_* = granted master's payload; for master 0, s_req_we = 0 and wdata/wstrb = 0.
  - Granted m*_req_ready = s_req_ready. Ungranted master sees req_ready = 0.
  - s_rsp_ready = 0.
  - On s_req_valid && s_req_ready: go to RSP and clear the watchdog.
- RSP:
  - s_req_valid = 0.
  - Granted m*_rsp_valid/data/resp = s_rsp_*; s_rsp_ready = granted m*_rsp_ready. Ungranted rsp_valid = 0.
  - On response handshake: last = gnt, go to IDLE.
  - Watchdog increments every RSP cycle without a handshake.
  - If the watchdog reaches TIMEOUT (and TIMEOUT != 0): next cycle the arbiter itself drives granted rsp_valid = 1, data = 0, resp = 2'b11 until accepted, then last = gnt and IDLE.
- Slave resp codes pass through unchanged. Write responses forward data as 0.
- A minimum of one IDLE cycle separates consecutive transactions, so there are no back-to-back grants.
- A new request arriving while another is granted waits; its ready stays 0. No request is ever lost or reordered within a master.

Test Plan:
- IFU read alone: m0 addr 0x3000_0000 at cycle 0; slave ready at cycle 2, response 0x0000_0413 at cycle 4 -> m0_req_ready=1 at cycle 2, m0_rsp_valid with data 0x0000_0413 at cycle 4, state IDLE at cycle 5.
- Simultaneous requests after reset: m0 read 0x3000_0004, m1 write 0x8000_0000 data 0xDEAD_BEEF strb 0xF -> IFU served first, then LSU. The slave sees the write with we=1 and strb=0xF. The next contest grants m0 again.
- Fairness: both masters request continuously for 6 transactions -> grants alternate 0,1,0,1,0,1.
- Backpressure: m1_rsp_ready low for 5 cycles while s_rsp_valid=1 -> s_rsp_ready=0 and the response is held. m0 is not granted until the LSU accepts.
- Timeout (TIMEOUT=4): slave never responds to an m0 read -> m0_rsp_valid=1 with resp=2'b11 and data 0 after 4 RSP cycles. A later stale slave response in IDLE is consumed and not forwarded.
- Reset mid-operation: reset=0 during REQ with m1 granted -> next cycle all valids/readies are 0 and the state is IDLE. After release, m0 wins a simultaneous contest.
